// File: rtl/apb_slave_mem.sv
// APB3 slave with a word-addressed register memory, programmable wait states
// and an error response for misaligned or out-of-range addresses.
module apb_slave_mem #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int unsigned MemAw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                state_q, state_d, phase;
  logic [3:0]            cnt_q, cnt_d;
  logic [MemAw-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic                  legal_q, legal_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  mem_we;
  logic                  addr_legal;

  // Word aligned and inside the memory; the index is zero-extended before the compare.
  assign addr_legal = (paddr[1:0] == 2'b00) && (32'(paddr[ADDR_WIDTH-1:2]) < DEPTH);

  // Phase decode, transfer latching, wait counting and completion outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    legal_d = legal_q;
    wdata_d = wdata_q;
    mem_we  = 1'b0;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;

    // The setup cycle is the one in which psel rises while idle, so it cannot be a
    // registered state without costing a cycle; it is recognised from IDLE here.
    // psel with penable but no prior setup is a protocol error and stays IDLE.
    phase = state_q;
    if (state_q == StIdle && psel && !penable) begin
      phase = StSetup;
    end

    case (phase)
      StSetup: begin
        idx_d   = paddr[MemAw+1:2];
        write_d = pwrite;
        legal_d = addr_legal;
        wdata_d = pwdata;
        cnt_d   = 4'(WAIT_STATES);
        state_d = StAccess;
      end
      StAccess: begin
        if (!psel) begin
          state_d = StIdle;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          pready  = 1'b1;
          pslverr = !legal_q;
          if (legal_q) begin
            if (write_q) begin
              mem_we = 1'b1;
            end else begin
              prdata = mem_q[idx_q];
            end
          end
          // A back-to-back setup is picked up by the IDLE decode next cycle.
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and latched-transfer registers.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
      legal_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      legal_q <= legal_d;
      wdata_q <= wdata_d;
    end
  end

  // Memory array: cleared by reset, written at the completion edge of a legal write.
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: four builds (WS=1, WS=3, WS=0, ADDR_WIDTH=9)
// share one APB bus, each with its own psel.
module tb_apb_slave_mem;

  logic        pclk;
  logic        preset;
  logic [3:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [8:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prd [4];
  logic        rdy [4];
  logic        err [4];

  int n_cmp = 0;
  int n_bad = 0;
  // Access cycles up to and including completion: WAIT_STATES + 1 per build.
  int exp_cyc [4] = '{2, 4, 1, 2};

  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(1)) u_dut_ws1 (
    .pclk(pclk), .preset(preset), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr[7:0]), .pwdata(pwdata), .prdata(prd[0]), .pready(rdy[0]), .pslverr(err[0])
  );
  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(3)) u_dut_ws3 (
    .pclk(pclk), .preset(preset), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr[7:0]), .pwdata(pwdata), .prdata(prd[1]), .pready(rdy[1]), .pslverr(err[1])
  );
  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)) u_dut_ws0 (
    .pclk(pclk), .preset(preset), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr[7:0]), .pwdata(pwdata), .prdata(prd[2]), .pready(rdy[2]), .pslverr(err[2])
  );
  apb_slave_mem #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(1)) u_dut_aw9 (
    .pclk(pclk), .preset(preset), .psel(psel[3]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prd[3]), .pready(rdy[3]), .pslverr(err[3])
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full transfer on build d; bus address/data are scrambled during access.
  task automatic xfer(input int d, input logic wr, input logic [8:0] addr,
                      input logic [31:0] wd, output logic [31:0] rdat,
                      output logic perr, output int ncyc);
    @(posedge pclk); #1;
    psel = '0; psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge pclk); #1;
    penable = 1'b1;
    paddr = ~addr;
    pwdata = ~wd;
    ncyc = 0;
    rdat = '0;
    perr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge pclk);
      ncyc++;
      if (rdy[d]) begin
        rdat = prd[d];
        perr = err[d];
        break;
      end
      @(posedge pclk); #1;
    end
  endtask

  task automatic do_wr(input int d, input logic [8:0] a, input logic [31:0] v,
                       input logic exp_err, input string tag);
    logic [31:0] r;
    logic        e;
    int          n;
    xfer(d, 1'b1, a, v, r, e, n);
    check({tag, " pslverr"}, 32'(e), 32'(exp_err));
    check({tag, " cycles"}, 32'(n), 32'(exp_cyc[d]));
  endtask

  task automatic do_rd(input int d, input logic [8:0] a, input logic [31:0] exp,
                       input logic exp_err, input string tag);
    logic [31:0] r;
    logic        e;
    int          n;
    xfer(d, 1'b0, a, 32'h0, r, e, n);
    check({tag, " prdata"}, r, exp);
    check({tag, " pslverr"}, 32'(e), 32'(exp_err));
    check({tag, " cycles"}, 32'(n), 32'(exp_cyc[d]));
  endtask

  // Bus idle; pready must be low on every build.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk); #1;
      psel = '0;
      penable = 1'b0;
      @(negedge pclk);
      check("idle pready", {28'h0, rdy[3], rdy[2], rdy[1], rdy[0]}, 32'h0);
    end
  endtask

  initial begin
    preset = 1'b1; psel = 4'hF; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;

    // Reset held two cycles with psel high.
    @(posedge pclk);
    @(negedge pclk);
    check("reset pready", {28'h0, rdy[3], rdy[2], rdy[1], rdy[0]}, 32'h0);
    check("reset pslverr", {28'h0, err[3], err[2], err[1], err[0]}, 32'h0);
    check("reset prdata", prd[0] | prd[1] | prd[2] | prd[3], 32'h0);
    @(posedge pclk); #1;
    preset = 1'b0; psel = '0;

    do_rd(0, 9'h010, 32'h0000_0000, 1'b0, "rd 10 after reset");

    // Write then read, WAIT_STATES=1.
    idle(1);
    do_wr(0, 9'h004, 32'hDEAD_BEEF, 1'b0, "wr 04");
    idle(1);
    do_rd(0, 9'h004, 32'hDEAD_BEEF, 1'b0, "rd 04");

    // Back-to-back, no idle cycles; read FC right after its write completes.
    do_wr(0, 9'h000, 32'h1111_1111, 1'b0, "b2b wr 00");
    do_wr(0, 9'h0FC, 32'h2222_2222, 1'b0, "b2b wr FC");
    do_rd(0, 9'h0FC, 32'h2222_2222, 1'b0, "b2b rd FC");
    do_rd(0, 9'h000, 32'h1111_1111, 1'b0, "b2b rd 00");
    idle(1);

    // Misaligned accesses error out and leave memory alone.
    do_wr(0, 9'h002, 32'h5A5A_5A5A, 1'b1, "wr 02 misaligned");
    do_rd(0, 9'h003, 32'h0000_0000, 1'b1, "rd 03 misaligned");
    do_rd(0, 9'h000, 32'h1111_1111, 1'b0, "rd 00 after bad wr");
    do_rd(0, 9'h0FC, 32'h2222_2222, 1'b0, "rd FC after bad wr");
    idle(1);

    // ADDR_WIDTH=9 build: index 64 is out of range and must not alias index 0.
    do_wr(3, 9'h000, 32'h1111_1111, 1'b0, "aw9 wr 000");
    do_wr(3, 9'h100, 32'h5A5A_5A5A, 1'b1, "aw9 wr 100");
    do_rd(3, 9'h100, 32'h0000_0000, 1'b1, "aw9 rd 100");
    do_rd(3, 9'h000, 32'h1111_1111, 1'b0, "aw9 rd 000");
    do_rd(3, 9'h0FC, 32'h0000_0000, 1'b0, "aw9 rd 0FC");
    idle(1);

    // WAIT_STATES=0 build: 2-cycle transfers.
    do_wr(2, 9'h00C, 32'h1234_5678, 1'b0, "ws0 wr 0C");
    do_rd(2, 9'h00C, 32'h1234_5678, 1'b0, "ws0 rd 0C");
    idle(1);

    // penable without a setup phase is ignored.
    @(posedge pclk); #1;
    psel = 4'b0100; penable = 1'b1; pwrite = 1'b1; paddr = 9'h00C; pwdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check("proto err pready", 32'(rdy[2]), 32'h0);
      @(posedge pclk); #1;
    end
    psel = '0; penable = 1'b0;
    idle(1);
    do_rd(2, 9'h00C, 32'h1234_5678, 1'b0, "ws0 rd 0C after proto err");
    idle(1);

    // WAIT_STATES=3: psel dropped in the second wait cycle aborts the write.
    do_wr(1, 9'h008, 32'h0000_00AA, 1'b0, "ws3 wr 08");
    idle(1);
    @(posedge pclk); #1;
    psel = 4'b0010; penable = 1'b0; pwrite = 1'b1; paddr = 9'h008; pwdata = 32'hCAFE_0001;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    check("abort wait1 pready", 32'(rdy[1]), 32'h0);
    @(posedge pclk); #1;
    psel = '0; penable = 1'b0;
    @(negedge pclk);
    check("abort wait2 pready", 32'(rdy[1]), 32'h0);
    idle(4);
    do_rd(1, 9'h008, 32'h0000_00AA, 1'b0, "rd 08 after abort");
    idle(1);

    // Reset in the middle of a WAIT_STATES=3 write: dropped and memory cleared.
    @(posedge pclk); #1;
    psel = 4'b0010; penable = 1'b0; pwrite = 1'b1; paddr = 9'h008; pwdata = 32'hCAFE_0001;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b1;
    @(negedge pclk);
    check("mid reset pready", 32'(rdy[1]), 32'h0);
    @(posedge pclk); #1;
    preset = 1'b0; psel = '0; penable = 1'b0;
    @(negedge pclk);
    check("post reset pready", 32'(rdy[1]), 32'h0);
    check("post reset pslverr", 32'(err[1]), 32'h0);
    check("post reset prdata", prd[1], 32'h0);
    do_rd(1, 9'h008, 32'h0000_0000, 1'b0, "rd 08 after mid reset");
    do_rd(0, 9'h004, 32'h0000_0000, 1'b0, "ws1 rd 04 after mid reset");
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
